pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the program counter. Generates the PC select code and the jump address,
//  runs the req/ack handshake with instruction memory, and absorbs decode stalls.
//  Handles branch/trap redirects, discards stale in-flight fetches, and counts delivered instructions.
//  Sits between the PC register, instruction memory and decode.
// PARAMETERS
//  TRAP_VEC  32'h0000_0100  redirect address for trap, timeout and misalign
//  TIMEOUT   255            max cycles waiting for imem_ack (>=1)
//  CNT_W     16             width of fetch_count
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  start          in   1      leave IDLE and begin fetching; ignored outside IDLE
//  imem_req       out  1      fetch request; address is the current PC output
//  imem_ack       in   1      memory returned instruction word this cycle
//  stall          in   1      decode cannot accept an instruction
//  branch_taken   in   1      redirect to branch_target
//  branch_target  in   32     redirect address
//  trap           in   1      redirect to TRAP_VEC; priority over branch_taken
//  pc_sel         out  2      PC select: 0=clear, 1=load jump_dir, 2=+4, 3=hold
//  jump_dir       out  32     TRAP_VEC on trap/timeout/misalign redirect, else branch_target
//  instr_valid    out  1      instruction word valid to decode
//  flush          out  1      one-cycle pulse on every redirect
//  timeout_err    out  1      one-cycle pulse on ack timeout
//  misalign_err   out  1      one-cycle pulse on misaligned branch target (macro only, else 0)
//  busy           out  1      state != IDLE
//  fetch_count    out  CNT_W  instructions handed to decode; wraps modulo 2^CNT_W
// BEHAVIOUR
//  - pc_sel, jump_dir, imem_req, instr_valid, flush are combinational from state+inputs (Mealy).
//  - The PC updates on the same clk edge. State, timer and fetch_count are registered.
//  - Reset (async): state=IDLE, timer=0, fetch_count=0; pc_sel=0, all 1-bit outputs 0.
//  - Reset mid-operation aborts everything; no drain.
//  - redirect = trap | branch_taken | timeout (| misalign). Redirect: pc_sel=1, flush=1, instr_valid=0.
//  - IDLE: pc_sel=0, imem_req=0. start -> FETCH. Redirects are ignored.
//  - FETCH: imem_req=1. Timer counts each cycle without ack and clears on ack or state change.
//    * redirect & imem_ack    -> ack word discarded, next FETCH.
//    * redirect & !imem_ack   -> DRAIN (request still outstanding).
//    * ack & !stall           -> instr_valid=1, pc_sel=2, fetch_count+1, stay FETCH (1 instr/cycle).
//    * ack & stall            -> instr_valid=1, pc_sel=3, go STALL.
//    * no ack, timer==TIMEOUT-1 -> timeout_err=1, redirect to TRAP_VEC, go DRAIN.
//    * otherwise              -> pc_sel=3.
//  - STALL: imem_req=0, instr_valid=1 (word held externally), pc_sel=3.
//    * !stall    -> pc_sel=2, fetch_count+1, go FETCH.
//    * redirect  -> go FETCH; word dropped, no count.
//  - DRAIN: imem_req=0, instr_valid=0, pc_sel=3; waits for the stale ack.
//    * imem_ack                    -> go FETCH (word discarded).
//    * redirect                    -> re-redirect (new target), stay DRAIN.
//    * timer reaches TIMEOUT-1     -> timeout_err=1, go FETCH, no further redirect.
//  - fetch_count increments only on a handoff (instr_valid & !stall & !redirect).
//  - Simultaneous trap & branch: trap wins, jump_dir=TRAP_VEC.
// CONFIGURATION
//  PCCTRL_ALIGN_CHK_EN defined:
//    - branch_taken with branch_target[1:0]!=0 -> misalign_err=1 and redirect to TRAP_VEC.
//    - Trap-path flush rules apply.
//  Not defined:
//    - misalign_err tied 0.
//    - branch_target passes to jump_dir unchanged; low bits are not checked.
// TESTING
//  1. rst, start, ack every cycle, stall=0 -> pc_sel=2 per ack, PC 0,4,8; fetch_count=3 after 3 acks.
//  2. ack with stall=1 for 2 cycles -> STALL; instr_valid high 3 cycles; pc_sel 3,3,2; count +1 once.
//  3. branch 0x40 while req outstanding, ack 2 cycles later -> pc_sel=1, 1-cycle flush, DRAIN,
//     stale ack gives instr_valid=0, next imem_req with PC=0x40.
//  4. trap and branch (0x80) in the same cycle -> jump_dir=0x100, flush=1, branch ignored.
//  5. TIMEOUT=4, no ack -> timeout_err on 4th wait cycle, pc_sel=1, jump_dir=0x100, DRAIN.
//  6. Macro on: branch 0x42 -> misalign_err=1, jump_dir=0x100. Macro off: jump_dir=0x42.
//     Async rst asserted mid-STALL -> IDLE immediately, pc_sel=0, instr_valid=0, fetch_count=0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch sequencer: PC select, imem req/ack handshake, stall absorb, redirect/drain.
// Optional misaligned-branch trap enabled by defining PCCTRL_ALIGN_CHK_EN.
module pc_fetch_ctrl #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_imem_req,
  input  logic             i_imem_ack,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [31:0]      i_branch_target,
  input  logic             i_trap,
  output logic [1:0]       o_pc_sel,
  output logic [31:0]      o_jump_dir,
  output logic             o_instr_valid,
  output logic             o_flush,
  output logic             o_timeout_err,
  output logic             o_misalign_err,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_fetch_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL, S_DRAIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_count;
  logic             w_misalign;
  logic             w_ext_redir;
  logic             w_timer_hit;
  logic             w_trap_vec;
  logic             w_inc;

`ifdef PCCTRL_ALIGN_CHK_EN
  assign w_misalign = i_branch_taken & (i_branch_target[1:0] != 2'b00) & (r_state != S_IDLE);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_ext_redir    = i_trap | i_branch_taken | w_misalign;
  assign w_timer_hit    = (r_timer == TMAX);
  assign o_misalign_err = w_misalign;
  assign o_busy         = (r_state != S_IDLE);
  assign o_fetch_count  = r_count;

  // Mealy output decode and next-state selection
  always_comb begin
    w_next        = r_state;
    o_pc_sel      = 2'd3;
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    o_flush       = 1'b0;
    o_timeout_err = 1'b0;
    w_trap_vec    = 1'b0;
    w_inc         = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_pc_sel = 2'd0;
        if (i_start) w_next = S_FETCH;
        else         w_next = S_IDLE;
      end
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (w_ext_redir) begin
          o_pc_sel   = 2'd1;
          o_flush    = 1'b1;
          w_trap_vec = i_trap | w_misalign;
          // an ack arriving with the redirect is the stale word; otherwise wait for it
          w_next     = i_imem_ack ? S_FETCH : S_DRAIN;
        end else if (i_imem_ack) begin
          o_instr_valid = 1'b1;
          if (i_stall) begin
            o_pc_sel = 2'd3;
            w_next   = S_STALL;
          end else begin
            o_pc_sel = 2'd2;
            w_inc    = 1'b1;
            w_next   = S_FETCH;
          end
        end else if (w_timer_hit) begin
          o_timeout_err = 1'b1;
          o_pc_sel      = 2'd1;
          o_flush       = 1'b1;
          w_trap_vec    = 1'b1;
          w_next        = S_DRAIN;
        end else begin
          o_pc_sel = 2'd3;
        end
      end
      S_STALL: begin
        if (w_ext_redir) begin
          o_pc_sel   = 2'd1;
          o_flush    = 1'b1;
          w_trap_vec = i_trap | w_misalign;
          w_next     = S_FETCH;
        end else if (!i_stall) begin
          o_instr_valid = 1'b1;
          o_pc_sel      = 2'd2;
          w_inc         = 1'b1;
          w_next        = S_FETCH;
        end else begin
          o_instr_valid = 1'b1;
          o_pc_sel      = 2'd3;
        end
      end
      S_DRAIN: begin
        if (w_ext_redir) begin
          o_pc_sel   = 2'd1;
          o_flush    = 1'b1;
          w_trap_vec = i_trap | w_misalign;
        end else begin
          o_pc_sel = 2'd3;
        end
        if (i_imem_ack) begin
          w_next = S_FETCH;
        end else if (w_timer_hit) begin
          o_timeout_err = 1'b1;
          w_next        = S_FETCH;
        end else begin
          w_next = S_DRAIN;
        end
      end
      default: begin
        o_pc_sel = 2'd0;
        w_next   = S_IDLE;
      end
    endcase
    o_jump_dir = w_trap_vec ? TRAP_VEC : i_branch_target;
  end

  // State, ack-wait timer and delivered-instruction counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_timer <= {TW{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || i_imem_ack ||
          ((r_state != S_FETCH) && (r_state != S_DRAIN))) begin
        r_timer <= {TW{1'b0}};
      end else begin
        r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
      end
      if (w_inc) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      else       r_count <= r_count;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl (TIMEOUT=4) with an expected-value queue and a model PC register.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] TRAP = 32'h0000_0100;
`ifdef PCCTRL_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, ack = 1'b0, stall = 1'b0, br = 1'b0, trap = 1'b0;
  logic [31:0] bt = 32'h0;
  logic        req, iv, fl, terr, merr, busy;
  logic [1:0]  pc_sel;
  logic [31:0] jd;
  logic [15:0] cnt;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [1:0]  pc_sel;
    logic        req, iv, fl, terr, merr, busy;
    logic [31:0] jd;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  pc_fetch_ctrl #(.TRAP_VEC(TRAP), .TIMEOUT(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_imem_req(req), .i_imem_ack(ack),
    .i_stall(stall), .i_branch_taken(br), .i_branch_target(bt), .i_trap(trap),
    .o_pc_sel(pc_sel), .o_jump_dir(jd), .o_instr_valid(iv), .o_flush(fl),
    .o_timeout_err(terr), .o_misalign_err(merr), .o_busy(busy), .o_fetch_count(cnt)
  );

  always #5 clk = ~clk;

  // External PC register steered by pc_sel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h0;
    else begin
      case (pc_sel)
        2'd0:    pc <= 32'h0;
        2'd1:    pc <= jd;
        2'd2:    pc <= pc + 32'd4;
        default: pc <= pc;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int id, input logic r, input logic s, input logic a, input logic st,
                      input logic b, input logic [31:0] t, input logic tr,
                      input logic [1:0] e_sel, input logic e_req, input logic e_iv,
                      input logic e_fl, input logic e_terr, input logic e_busy,
                      input logic [15:0] e_cnt);
    exp_t e, g;
    @(negedge clk);
    rst = r; start = s; ack = a; stall = st; br = b; bt = t; trap = tr;
    e.id = id; e.pc_sel = e_sel; e.req = e_req; e.iv = e_iv; e.fl = e_fl;
    e.terr = e_terr; e.busy = e_busy; e.cnt = e_cnt;
    e.merr = ALIGN && b && (t[1:0] != 2'b00) && e_busy;
    e.jd = (tr || e_terr || e.merr) ? TRAP : t;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk($sformatf("s%0d.pc_sel", g.id), {30'h0, pc_sel}, {30'h0, g.pc_sel});
    chk($sformatf("s%0d.imem_req", g.id), {31'h0, req}, {31'h0, g.req});
    chk($sformatf("s%0d.instr_valid", g.id), {31'h0, iv}, {31'h0, g.iv});
    chk($sformatf("s%0d.flush", g.id), {31'h0, fl}, {31'h0, g.fl});
    chk($sformatf("s%0d.timeout_err", g.id), {31'h0, terr}, {31'h0, g.terr});
    chk($sformatf("s%0d.misalign_err", g.id), {31'h0, merr}, {31'h0, g.merr});
    chk($sformatf("s%0d.busy", g.id), {31'h0, busy}, {31'h0, g.busy});
    chk($sformatf("s%0d.fetch_count", g.id), {16'h0, cnt}, {16'h0, g.cnt});
    if (g.fl) chk($sformatf("s%0d.jump_dir", g.id), jd, g.jd);
  endtask

  initial begin
    //      id rst st ack stl br target tr  sel req iv fl te busy cnt
    step( 1, 1, 0, 0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0, 0, 0, 16'd0);
    step( 2, 0, 1, 0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0, 0, 0, 16'd0);
    // streaming fetch
    step( 3, 0, 0, 1, 0, 0, 32'h0, 0, 2'd2, 1, 1, 0, 0, 1, 16'd0);
    chk("pc0", pc, 32'h0);
    step( 4, 0, 0, 1, 0, 0, 32'h0, 0, 2'd2, 1, 1, 0, 0, 1, 16'd1);
    chk("pc4", pc, 32'h4);
    step( 5, 0, 0, 1, 0, 0, 32'h0, 0, 2'd2, 1, 1, 0, 0, 1, 16'd2);
    chk("pc8", pc, 32'h8);
    step( 6, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 1, 0, 0, 0, 1, 16'd3);
    // decode stall for two cycles
    step( 7, 0, 0, 1, 1, 0, 32'h0, 0, 2'd3, 1, 1, 0, 0, 1, 16'd3);
    step( 8, 0, 0, 0, 1, 0, 32'h0, 0, 2'd3, 0, 1, 0, 0, 1, 16'd3);
    step( 9, 0, 0, 0, 0, 0, 32'h0, 0, 2'd2, 0, 1, 0, 0, 1, 16'd3);
    // branch with request outstanding, stale ack drained
    step(10, 0, 0, 0, 0, 1, 32'h40, 0, 2'd1, 1, 0, 1, 0, 1, 16'd4);
    step(11, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 0, 0, 0, 0, 1, 16'd4);
    step(12, 0, 0, 1, 0, 0, 32'h0, 0, 2'd3, 0, 0, 0, 0, 1, 16'd4);
    step(13, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 1, 0, 0, 0, 1, 16'd4);
    chk("pc_branch", pc, 32'h40);
    // trap and branch together, ack discarded
    step(14, 0, 0, 1, 0, 1, 32'h80, 1, 2'd1, 1, 0, 1, 0, 1, 16'd4);
    // ack timeout in FETCH (4th wait cycle)
    step(15, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 1, 0, 0, 0, 1, 16'd4);
    chk("pc_trap", pc, TRAP);
    step(16, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 1, 0, 0, 0, 1, 16'd4);
    step(17, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 1, 0, 0, 0, 1, 16'd4);
    step(18, 0, 0, 0, 0, 0, 32'h0, 0, 2'd1, 1, 0, 1, 1, 1, 16'd4);
    // timeout again in DRAIN: no redirect, back to FETCH
    step(19, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 0, 0, 0, 0, 1, 16'd4);
    step(20, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 0, 0, 0, 0, 1, 16'd4);
    step(21, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 0, 0, 0, 0, 1, 16'd4);
    step(22, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 0, 0, 0, 1, 1, 16'd4);
    step(23, 0, 0, 1, 0, 0, 32'h0, 0, 2'd2, 1, 1, 0, 0, 1, 16'd4);
    // misaligned branch target
    step(24, 0, 0, 0, 0, 1, 32'h42, 0, 2'd1, 1, 0, 1, 0, 1, 16'd5);
    step(25, 0, 0, 1, 0, 0, 32'h0, 0, 2'd3, 0, 0, 0, 0, 1, 16'd5);
    // async reset in the middle of a stall
    step(26, 0, 0, 1, 1, 0, 32'h0, 0, 2'd3, 1, 1, 0, 0, 1, 16'd5);
    step(27, 0, 0, 0, 1, 0, 32'h0, 0, 2'd3, 0, 1, 0, 0, 1, 16'd5);
    step(28, 1, 0, 0, 1, 0, 32'h0, 0, 2'd0, 0, 0, 0, 0, 0, 16'd0);
    step(29, 0, 1, 0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0, 0, 0, 16'd0);
    step(30, 0, 0, 1, 0, 0, 32'h0, 0, 2'd2, 1, 1, 0, 0, 1, 16'd0);
    chk("pc_after_rst", pc, 32'h0);
    step(31, 0, 0, 0, 0, 0, 32'h0, 0, 2'd3, 1, 0, 0, 0, 1, 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
